// File: rtl/note_plot_scheduler_pkg.sv
// Shared types and constants for the note-highway plot scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package note_plot_scheduler_pkg;

    // Default geometry of the note register and plotter handshake.
    localparam int DEF_ROWS        = 8;
    localparam int DEF_LANES       = 5;
    localparam int DEF_ACK_TIMEOUT = 255;

    // Scheduler state encoding (kept as plain constants for legacy tools).
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_SCAN  = 3'd3;
    localparam logic [2:0] ST_ISSUE = 3'd4;
    localparam logic [2:0] ST_WAIT  = 3'd5;
    localparam logic [2:0] ST_SHIFT = 3'd6;
    localparam logic [2:0] ST_DONE  = 3'd7;

    // Which pass over the register is running.
    typedef enum logic {
        PASS_ERASE = 1'b0,
        PASS_DRAW  = 1'b1
    } pass_e;

    // Lane codes as seen by the plotter; bit k of a row word is lane k+1.
    localparam logic [2:0] LANE_GREEN  = 3'd1;
    localparam logic [2:0] LANE_RED    = 3'd2;
    localparam logic [2:0] LANE_YELLOW = 3'd3;
    localparam logic [2:0] LANE_BLUE   = 3'd4;
    localparam logic [2:0] LANE_ORANGE = 3'd5;

endpackage

// File: rtl/note_lane_pick.sv
// Lowest-set-bit picker over a row mask: returns the lane code and the mask minus that lane.
// Latency: combinational.
// Backpressure: none.
// Ports: mask (in, LANES), found (out), lane (out, 3 bits, 1..LANES), rest (out, mask with picked bit cleared).
module note_lane_pick
    import note_plot_scheduler_pkg::*;
#(
    parameter int LANES = DEF_LANES
) (
    input  logic [LANES-1:0] mask,
    output logic             found,
    output logic [2:0]       lane,
    output logic [LANES-1:0] rest
);

    localparam logic [LANES-1:0] ONE = LANES'(1);

    // Walk from the top bit down so the lowest set bit is the last one to win.
    always_comb begin
        found = 1'b0;
        lane  = 3'd0;
        rest  = mask;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                found = 1'b1;
                lane  = LANE_GREEN + 3'(i);
                rest  = mask & ~(ONE << i);
            end
        end
    end

endmodule

// File: rtl/note_plot_scheduler.sv
// Frame sequencer: per frame_tick, erase held notes, advance the note register, draw the new rows.
// Latency: empty register = 52 cycles tick-to-frame_done with erase (28 without), shift_ack after 1 cycle.
// Backpressure: one plot job in flight; waits on plot_ack (abandons after ACK_TIMEOUT) and shift_ack.
//
// Ports: clk, resetn (async active-low); frame_tick/pause start control; row_addr/row_data note
// register read (1-cycle read latency); shift_req/shift_ack register advance handshake;
// plot_req/plot_erase/plot_lane/plot_row/plot_ack plotter job handshake; busy, frame_done,
// sticky overrun and ack_err status.
// Build option: define NOTE_SCHED_ERASE_EN to run the erase pass before the shift.
module note_plot_scheduler
    import note_plot_scheduler_pkg::*;
#(
    parameter int ROWS        = DEF_ROWS,
    parameter int LANES       = DEF_LANES,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             frame_tick,
    input  logic             pause,
    output logic [2:0]       row_addr,
    input  logic [LANES-1:0] row_data,
    output logic             shift_req,
    input  logic             shift_ack,
    output logic             plot_req,
    output logic             plot_erase,
    output logic [2:0]       plot_lane,
    output logic [2:0]       plot_row,
    input  logic             plot_ack,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun,
    output logic             ack_err
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [2:0]    LAST_ROW = 3'(ROWS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    logic [2:0]       state;
    pass_e            pass;
    logic [2:0]       row;
    logic [LANES-1:0] mask;
    logic [TW-1:0]    tmo_cnt;

    logic             pick_found;
    logic [2:0]       pick_lane;
    logic [LANES-1:0] pick_rest;

    note_lane_pick #(.LANES(LANES)) u_pick (
        .mask  (mask),
        .found (pick_found),
        .lane  (pick_lane),
        .rest  (pick_rest)
    );

    // The row counter is itself the read address: it changes on entry to FETCH,
    // so the register word is valid during LATCH.
    assign row_addr = row;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            pass       <= PASS_ERASE;
            row        <= 3'd0;
            mask       <= '0;
            tmo_cnt    <= '0;
            shift_req  <= 1'b0;
            plot_req   <= 1'b0;
            plot_erase <= 1'b0;
            plot_lane  <= 3'd0;
            plot_row   <= 3'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            ack_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // Frames never queue: a tick outside IDLE only leaves a sticky mark.
            if (frame_tick && state != ST_IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (frame_tick && !pause) begin
                        busy <= 1'b1;
                        row  <= 3'd0;
`ifdef NOTE_SCHED_ERASE_EN
                        pass  <= PASS_ERASE;
                        state <= ST_FETCH;
`else
                        shift_req <= 1'b1;
                        state     <= ST_SHIFT;
`endif
                    end
                end

                ST_FETCH: begin
                    state <= ST_LATCH;
                end

                ST_LATCH: begin
                    mask  <= row_data;
                    state <= ST_SCAN;
                end

                ST_SCAN: begin
                    if (pick_found) begin
                        plot_lane <= pick_lane;
                        mask      <= pick_rest;
                        state     <= ST_ISSUE;
                    end else if (row != LAST_ROW) begin
                        row   <= row + 3'd1;
                        state <= ST_FETCH;
                    end else if (pass == PASS_ERASE) begin
                        shift_req <= 1'b1;
                        state     <= ST_SHIFT;
                    end else begin
                        state <= ST_DONE;
                    end
                end

                ST_ISSUE: begin
                    plot_req <= 1'b1;
                    plot_row <= row;
`ifdef NOTE_SCHED_ERASE_EN
                    plot_erase <= (pass == PASS_ERASE);
`endif
                    tmo_cnt <= '0;
                    state   <= ST_WAIT;
                end

                ST_WAIT: begin
                    // Ack is checked first so an ack on the last allowed cycle still succeeds.
                    if (plot_ack) begin
                        plot_req <= 1'b0;
                        state    <= ST_SCAN;
                    end else if (tmo_cnt == TMO_LAST) begin
                        ack_err  <= 1'b1;
                        plot_req <= 1'b0;
                        state    <= ST_SCAN;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                ST_SHIFT: begin
                    if (shift_ack) begin
                        shift_req <= 1'b0;
                        pass      <= PASS_DRAW;
                        row       <= 3'd0;
                        state     <= ST_FETCH;
                    end
                end

                ST_DONE: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_plot_scheduler.sv
// Scoreboard bench for note_plot_scheduler: models the note register and plotter, checks job order and timing.
// Latency: n/a.
// Backpressure: plotter/shift ack delays are programmable; plotter can be made to never ack.
module tb_note_plot_scheduler;

`ifdef NOTE_SCHED_ERASE_EN
    localparam bit ERASE_ON = 1'b1;
`else
    localparam bit ERASE_ON = 1'b0;
`endif
    localparam int SHIFT_DLY = 1;
    localparam int BASE_LAT  = ERASE_ON ? 52 : 28;

    typedef struct packed {
        logic       erase;
        logic [2:0] lane;
        logic [2:0] row;
    } job_t;

    logic       clk;
    logic       resetn;
    logic       frame_tick;
    logic       pause;
    logic [2:0] row_addr;
    logic [4:0] row_data;
    logic       shift_req;
    logic       shift_ack;
    logic       plot_req;
    logic       plot_erase;
    logic [2:0] plot_lane;
    logic [2:0] plot_row;
    logic       plot_ack;
    logic       busy;
    logic       frame_done;
    logic       overrun;
    logic       ack_err;

    note_plot_scheduler dut (
        .clk        (clk),
        .resetn     (resetn),
        .frame_tick (frame_tick),
        .pause      (pause),
        .row_addr   (row_addr),
        .row_data   (row_data),
        .shift_req  (shift_req),
        .shift_ack  (shift_ack),
        .plot_req   (plot_req),
        .plot_erase (plot_erase),
        .plot_lane  (plot_lane),
        .plot_row   (plot_row),
        .plot_ack   (plot_ack),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun),
        .ack_err    (ack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Note register model: pre-shift and post-shift contents, synchronous read.
    logic [4:0] mem [8];
    logic [4:0] next_mem [8];
    logic       shifted;
    always @(posedge clk) row_data <= shifted ? next_mem[row_addr] : mem[row_addr];

    job_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   frames = 0, jobs = 0, shifts = 0;
    int   tick_cyc = 0, last_lat = -1, last_wait = -1, req_len = 0;
    int   sh_cnt = 0, pl_cnt = 0, plot_dly = 1;
    bit   plot_hang = 1'b0;
    bit   req_q = 1'b0, sreq_q = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // One cycle: observe outputs at the falling edge, then update the responders.
    task automatic step();
        job_t e;
        @(negedge clk);
        if (!resetn) begin
            req_q = 1'b0; sreq_q = 1'b0; shift_ack = 1'b0; plot_ack = 1'b0;
            sh_cnt = 0; pl_cnt = 0; req_len = 0;
        end else begin
            if (plot_req && !req_q) begin
                jobs++;
                req_len = 0;
                if (exp_q.size() == 0) begin
                    chk("job_extra", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("job_erase", plot_erase, e.erase);
                    chk("job_lane", plot_lane, e.lane);
                    chk("job_row", plot_row, e.row);
                end
            end
            if (plot_req) req_len++;
            else if (req_q) last_wait = req_len;
            if (shift_req && !sreq_q) shifts++;
            if (frame_done) begin
                frames++;
                last_lat = cyc - tick_cyc;
            end
            req_q  = plot_req;
            sreq_q = shift_req;

            if (shift_ack) begin
                shift_ack = 1'b0;
                sh_cnt = 0;
            end else if (shift_req) begin
                sh_cnt++;
                if (sh_cnt > SHIFT_DLY) begin
                    shift_ack = 1'b1;
                    shifted = 1'b1;
                end
            end
            if (plot_ack) begin
                plot_ack = 1'b0;
                pl_cnt = 0;
            end else if (plot_req && !plot_hang) begin
                pl_cnt++;
                if (pl_cnt > plot_dly) plot_ack = 1'b1;
            end else begin
                pl_cnt = 0;
            end
        end
    endtask

    function automatic logic [39:0] rw(input int r, input logic [4:0] v);
        return 40'(v) << (5 * r);
    endfunction

    // Load register contents and push the jobs a correct scheduler must issue.
    task automatic load(input logic [39:0] pre, input logic [39:0] post, output int njobs);
        job_t j;
        njobs = 0;
        shifted = 1'b0;
        for (int r = 0; r < 8; r++) begin
            mem[r]      = pre[r*5 +: 5];
            next_mem[r] = post[r*5 +: 5];
        end
        if (ERASE_ON) begin
            for (int r = 0; r < 8; r++)
                for (int k = 0; k < 5; k++)
                    if (pre[r*5 + k]) begin
                        j.erase = 1'b1; j.lane = 3'(k + 1); j.row = 3'(r);
                        exp_q.push_back(j);
                        njobs++;
                    end
        end
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 5; k++)
                if (post[r*5 + k]) begin
                    j.erase = 1'b0; j.lane = 3'(k + 1); j.row = 3'(r);
                    exp_q.push_back(j);
                    njobs++;
                end
    endtask

    task automatic tick(input bit stamp);
        step();
        frame_tick = 1'b1;
        if (stamp) tick_cyc = cyc;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input int target, input int budget);
        for (int i = 0; i < budget && frames < target; i++) step();
        chk({tag, "_done"}, frames, target);
    endtask

    task automatic run_frame(input string tag, input int exp_lat, input int budget);
        int f0;
        f0 = frames;
        tick(1'b1);
        chk({tag, "_busy"}, busy, 1);
        wait_frame(tag, f0 + 1, budget);
        chk({tag, "_lat"}, last_lat, exp_lat);
    endtask

    initial begin
        int nj, f0, j0, s0, busy_cnt;
        resetn = 1'b0; frame_tick = 1'b0; pause = 1'b0;
        shift_ack = 1'b0; plot_ack = 1'b0; shifted = 1'b0;
        for (int r = 0; r < 8; r++) begin
            mem[r] = 5'd0;
            next_mem[r] = 5'd0;
        end
        repeat (3) step();
        chk("rst_outputs", {row_addr, plot_lane, plot_row, plot_erase, plot_req, shift_req,
                            busy, frame_done, overrun, ack_err}, 0);
        resetn = 1'b1;
        step();

        // Empty register: no jobs, one shift handshake.
        load(40'd0, 40'd0, nj);
        plot_dly = 1; j0 = jobs; s0 = shifts;
        run_frame("empty", BASE_LAT, 300);
        chk("empty_jobs", jobs - j0, 0);
        chk("empty_shifts", shifts - s0, 1);
        chk("empty_busy_after", busy, 0);

        // Notes in two rows, before and after the shift.
        load(rw(3, 5'b10001), rw(4, 5'b00100), nj);
        plot_dly = 3; j0 = jobs;
        run_frame("notes", BASE_LAT + nj * (3 + plot_dly), 400);
        chk("notes_jobs", jobs - j0, nj);
        chk("notes_q", exp_q.size(), 0);

        // Ack on the very last allowed WAIT cycle is a success.
        load(40'd0, rw(6, 5'b01000), nj);
        plot_dly = 254;
        run_frame("edge", BASE_LAT + nj * (3 + plot_dly), 1000);
        chk("edge_wait", last_wait, 255);
        chk("edge_ack_err", ack_err, 0);

        // Plotter never acks: abandon after 255 WAIT cycles, frame still completes.
        load(40'd0, rw(2, 5'b00010), nj);
        plot_hang = 1'b1;
        run_frame("hang", BASE_LAT + nj * (2 + 255), 1000);
        chk("hang_wait", last_wait, 255);
        chk("hang_ack_err", ack_err, 1);
        chk("hang_q", exp_q.size(), 0);
        plot_hang = 1'b0;

        // Tick mid-frame is dropped and flagged.
        chk("ovr_pre", overrun, 0);
        load(40'd0, 40'd0, nj);
        plot_dly = 1; f0 = frames;
        tick(1'b1);
        repeat (10) step();
        tick(1'b0);
        wait_frame("ovr", f0 + 1, 300);
        chk("ovr_lat", last_lat, BASE_LAT);
        chk("ovr_flag", overrun, 1);
        repeat (80) step();
        chk("ovr_single", frames, f0 + 1);

        // Reset while waiting on the plotter.
        load(40'd0, rw(0, 5'b00001), nj);
        plot_hang = 1'b1; f0 = frames;
        tick(1'b1);
        for (int i = 0; i < 200 && !plot_req; i++) step();
        chk("rw_req_seen", plot_req, 1);
        repeat (3) step();
        #2 resetn = 1'b0;
        #1;
        chk("rw_plot_req", plot_req, 0);
        chk("rw_busy", busy, 0);
        chk("rw_overrun", overrun, 0);
        exp_q.delete();
        step();
        step();
        resetn = 1'b1;
        plot_hang = 1'b0;
        repeat (60) step();
        chk("rw_no_done", frames, f0);
        load(40'd0, rw(0, 5'b00001), nj);
        plot_dly = 2;
        run_frame("fresh", BASE_LAT + nj * (3 + plot_dly), 400);
        chk("fresh_q", exp_q.size(), 0);

        // Pause holds off ticks without flagging overrun.
        pause = 1'b1; f0 = frames; busy_cnt = 0;
        for (int t = 0; t < 3; t++) begin
            tick(1'b0);
            for (int i = 0; i < 5; i++) begin
                step();
                if (busy) busy_cnt++;
            end
        end
        chk("pause_busy", busy_cnt, 0);
        chk("pause_frames", frames, f0);
        chk("pause_overrun", overrun, 0);
        pause = 1'b0;
        load(40'd0, 40'd0, nj);
        run_frame("unpause", BASE_LAT, 300);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/note_plot_scheduler.md
# note_plot_scheduler

Frame-level sequencer for the note-highway plotter path. On each frame tick it erases every note currently held in the 8-row note register, requests the register to advance one row, and then draws the new contents. It feeds one (lane, row, erase) job at a time into the square plotter and waits for that plotter's done pulse. It sits between the rate divider / note register and the plotter, and replaces the free-running x/y counter pair.

## Interface
Parameters:
- ROWS, 8: rows in the note register; row index width is 3.
- LANES, 5: note lanes per row; lane codes are 1..LANES.
- ACK_TIMEOUT, 255: cycles to wait for plot_ack before abandoning a job.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse that starts a frame.
- pause  in  1  level; while high, frame_tick is ignored.
- row_addr  out  3  note-register read address; registered.
- row_data  in  5  note-register word; valid 1 cycle after row_addr changes. Bit k is lane k+1.
- shift_req  out  1  level; asks the note register to advance.
- shift_ack  in  1  one-cycle pulse; the register has advanced.
- plot_req  out  1  level; a plot job is pending.
- plot_erase  out  1  1 = clear the square, 0 = draw it. Stable while plot_req is high.
- plot_lane  out  3  lane 1..5. Stable while plot_req is high.
- plot_row  out  3  row 0..7. Stable while plot_req is high.
- plot_ack  in  1  one-cycle done pulse from the plotter.
- busy  out  1  high from frame start until frame_done.
- frame_done  out  1  one-cycle pulse at the end of a frame.
- overrun  out  1  sticky; a frame_tick arrived while busy.
- ack_err  out  1  sticky; a plot_ack timeout occurred.

## Operation
States:
- IDLE: waits for frame_tick while pause is low.
  - If NOTE_SCHED_ERASE_EN is defined: sets pass to ERASE and goes to FETCH.
  - Otherwise: goes to SHIFT.
- FETCH: drives row_addr = row, then goes to LATCH.
- LATCH: captures row_data into a 5-bit mask, then goes to SCAN.
- SCAN: acts on the mask.
  - mask == 0 and row < ROWS-1: row += 1, go to FETCH.
  - mask == 0 and row == ROWS-1: end of pass. After ERASE, go to SHIFT; after DRAW, go to DONE.
  - mask != 0: pick the lowest set bit k, set plot_lane = k+1, clear bit k, go to ISSUE.
- ISSUE: raises plot_req with plot_erase = (pass == ERASE) and plot_row = row. Loads the timeout counter and goes to WAIT.
- WAIT: stays until plot_ack, then drops plot_req and returns to SCAN.
  - If the counter reaches ACK_TIMEOUT first: set ack_err, drop plot_req, return to SCAN.
- SHIFT: holds shift_req until shift_ack. Then drops shift_req, sets pass to DRAW, row = 0, and goes to FETCH.
- DONE: pulses frame_done and goes to IDLE.

Rules:
- Empty lanes are never issued. Lane order within a row is 1 to 5; row order is 0 to 7.
- A frame_tick seen in any state other than IDLE sets overrun and is otherwise dropped; frames never queue.
- pause is only sampled in IDLE. A frame already in progress always completes.
- overrun and ack_err clear only on reset.

## Timing
- Reset: state goes to IDLE and all outputs are 0 (row_addr, plot_lane, plot_row, plot_erase, plot_req, shift_req, busy, frame_done, overrun, ack_err). Row, mask and timeout counter also clear.
- Reset mid-frame abandons the frame immediately; no frame_done is produced.
- busy rises the cycle after an accepted frame_tick and falls together with the frame_done pulse.
- Row cost: an empty row costs 3 cycles (FETCH, LATCH, SCAN). Each set bit adds 2 cycles plus the plotter's ack latency.
- Empty register, ERASE enabled: a shift_ack returned in 1 cycle gives tick-to-frame_done = 52 cycles.
- plot_ack and shift_ack are sampled only in WAIT and SHIFT respectively. An ack arriving in the same cycle as the req rising edge is ignored.
- An ack arriving on the exact timeout cycle counts as success; ack_err is not set.

## Configuration
- NOTE_SCHED_ERASE_EN defined: the ERASE pass runs before SHIFT, and plot_erase is driven as described above.
- NOTE_SCHED_ERASE_EN undefined: the ERASE pass is omitted, plot_erase is tied to 0, and IDLE goes straight to SHIFT. This is for builds where a background reload clears the screen.

## Structure
- Shared package contents: the state encoding, the ERASE/DRAW pass enum, lane constants (GREEN = 1 … ORANGE = 5), and ROWS/LANES defaults.
- One sub-module, note_lane_pick: a combinational lowest-set-bit picker.
  - Input: 5-bit mask.
  - Outputs: found, lane 1..5, and the mask with that bit cleared.

## Test plan
- Empty register, ack delay 1, ERASE enabled: one tick produces no plot_req, one shift handshake, and frame_done 52 cycles after the tick.
- Row 3 = 5'b10001 before shift, row 4 = 5'b00100 after shift: expect jobs (erase, 1, 3), (erase, 5, 3), (draw, 3, 4), in that order.
- frame_tick issued mid-frame: overrun goes to 1, the frame count is unchanged, and exactly one frame_done is produced.
- plotter never acks, single note: ack_err is set after 255 cycles of WAIT, and the frame still completes with frame_done.
- resetn asserted during WAIT: plot_req, busy and overrun go to 0 asynchronously. The next tick runs a full fresh frame.
- pause = 1 with ticks applied: busy stays 0. When pause is released, the next tick is accepted.
